// File: rtl/ce_cadence_monitor_pkg.sv
// ce_cadence_monitor_pkg: shared state encoding, phase width and strobe bit positions for the cadence monitor.
package ce_cadence_monitor_pkg;
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;
  localparam int PHASE_W = 6;
  localparam int NUM_STROBES = 7;
  localparam logic [PHASE_W-1:0] SYNC_PHASE = 6'd32;
  localparam int IDX_CE12 = 0;
  localparam int IDX_CE6 = 1;
  localparam int IDX_CE6X = 2;
  localparam int IDX_CE3 = 3;
  localparam int IDX_VIDEO_SLICE = 4;
  localparam int IDX_PIPE_AB = 5;
  localparam int IDX_CE1M5 = 6;
endpackage

// File: rtl/ce_cadence_decode.sv
// ce_cadence_decode: maps the generator phase to the seven expected strobes and flags the last phase of a frame.
module ce_cadence_decode
  import ce_cadence_monitor_pkg::*;
(
  input  logic [PHASE_W-1:0]     phase,
  output logic [NUM_STROBES-1:0] strobes,
  output logic                   frame_end
);
  always_comb begin
    strobes = '0;
    strobes[IDX_CE12] = phase[0];
    strobes[IDX_CE6] = phase[1] & phase[0];
    strobes[IDX_CE6X] = phase[1] & ~phase[0];
    strobes[IDX_CE3] = phase[2] & phase[1] & ~phase[0];
    strobes[IDX_VIDEO_SLICE] = ~phase[2];
    strobes[IDX_PIPE_AB] = phase[5];
    strobes[IDX_CE1M5] = ~phase[3] & phase[2] & phase[1] & ~phase[0];
    frame_end = &phase;
  end
endmodule

// File: rtl/ce_cadence_monitor.sv
// ce_cadence_monitor: recovers the clock generator phase from pipe_ab, predicts every strobe
// and reports lock state, per-cycle mismatches and a saturating error count.
module ce_cadence_monitor
  import ce_cadence_monitor_pkg::*;
#(
  parameter int LOCK_CYCLES = 128,
  parameter int ERR_LIMIT   = 3,
  parameter int CNT_W       = 8
) (
  input  logic               clk24,
  input  logic               reset_n,
  input  logic               ce12,
  input  logic               ce6,
  input  logic               ce6x,
  input  logic               ce3,
  input  logic               video_slice,
  input  logic               pipe_ab,
  input  logic               ce1m5,
  input  logic               clr_err,
  output logic               locked,
  output logic [5:0]         phase,
  output logic               err_pulse,
  output logic [6:0]         err_mask,
  output logic [CNT_W-1:0]   err_count
);
  localparam int GC_W = $clog2(LOCK_CYCLES + 1);
  localparam int FE_W = $clog2(ERR_LIMIT + 1);

  state_e                 state_q, state_d;
  logic [PHASE_W-1:0]     phase_q, phase_d;
  logic                   pipe_prev_q, pipe_prev_d;
  logic [GC_W-1:0]        good_ctr_q, good_ctr_d;
  logic [FE_W-1:0]        frame_err_q, frame_err_d, fe_inc;
  logic                   locked_q, locked_d;
  logic                   err_pulse_q, err_pulse_d;
  logic [NUM_STROBES-1:0] err_mask_q, err_mask_d;
  logic [CNT_W-1:0]       err_count_q, err_count_d;
  logic [NUM_STROBES-1:0] expected, observed, mism;
  logic                   frame_end;

  ce_cadence_decode u_decode (
    .phase     (phase_q),
    .strobes   (expected),
    .frame_end (frame_end)
  );

  assign observed = {ce1m5, pipe_ab, video_slice, ce3, ce6x, ce6, ce12};
  assign mism = observed ^ expected;
  assign fe_inc = frame_err_q + 1'b1;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    good_ctr_d = good_ctr_q;
    frame_err_d = frame_err_q;
    err_mask_d = '0;
    pipe_prev_d = pipe_ab;
    if (state_q == SEARCH) begin
      if (pipe_ab && !pipe_prev_q) begin
        state_d = VERIFY;
        phase_d = SYNC_PHASE + 6'd1;
        good_ctr_d = '0;
      end
    end else begin
      phase_d = phase_q + 6'd1;
      err_mask_d = mism;
      if (state_q == VERIFY) begin
        if (|mism) state_d = SEARCH;
        else if (good_ctr_q == GC_W'(LOCK_CYCLES - 1)) begin
          state_d = LOCKED;
          frame_err_d = '0;
        end else good_ctr_d = good_ctr_q + 1'b1;
      end else if (|mism && fe_inc == FE_W'(ERR_LIMIT)) begin
        state_d = SEARCH;
        frame_err_d = '0;
      end else frame_err_d = frame_end ? '0 : (|mism ? fe_inc : frame_err_q);
    end
    err_pulse_d = |err_mask_d;
    locked_d = state_d == LOCKED;
    err_count_d = clr_err ? '0 : (err_pulse_d && !(&err_count_q)) ? err_count_q + 1'b1 : err_count_q;
  end

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEARCH;
      phase_q <= '0;
      pipe_prev_q <= 1'b0;
      good_ctr_q <= '0;
      frame_err_q <= '0;
      locked_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_mask_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pipe_prev_q <= pipe_prev_d;
      good_ctr_q <= good_ctr_d;
      frame_err_q <= frame_err_d;
      locked_q <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_mask_q <= err_mask_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked = locked_q;
  assign phase = phase_q;
  assign err_pulse = err_pulse_q;
  assign err_mask = err_mask_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_ce_cadence_monitor.sv
// tb_ce_cadence_monitor: drives a free-running generator with injected glitches and scores the monitor
// against a cycle model through an expectation queue, plus directed checks of the key scenarios.
module tb_ce_cadence_monitor;
  localparam int LOCK_CYCLES = 128;
  localparam int ERR_LIMIT = 3;
  logic clk24 = 1'b0;
  logic reset_n = 1'b1;
  logic ce12 = 1'b0, ce6 = 1'b0, ce6x = 1'b0, ce3 = 1'b0, video_slice = 1'b0, pipe_ab = 1'b0, ce1m5 = 1'b0;
  logic clr_err = 1'b0;
  logic locked, err_pulse;
  logic [5:0] phase;
  logic [6:0] err_mask;
  logic [7:0] err_count;
  int total = 0, bad = 0;
  int m_st, m_ph, m_good, m_fe, m_cnt, gp, cyc, sync_cyc;
  logic m_prev;
  logic [22:0] exp_q[$];

  always #5 clk24 = ~clk24;

  ce_cadence_monitor dut (
    .clk24(clk24), .reset_n(reset_n), .ce12(ce12), .ce6(ce6), .ce6x(ce6x), .ce3(ce3),
    .video_slice(video_slice), .pipe_ab(pipe_ab), .ce1m5(ce1m5), .clr_err(clr_err),
    .locked(locked), .phase(phase), .err_pulse(err_pulse), .err_mask(err_mask), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [6:0] gen(input int p);
    logic [5:0] b;
    b = p[5:0];
    return {~b[3] & b[2] & b[1] & ~b[0], b[5], ~b[2], b[2] & b[1] & ~b[0], b[1] & ~b[0], b[1] & b[0], b[0]};
  endfunction

  task automatic step(input logic [6:0] inj, input logic clr);
    logic [6:0] obs, mm;
    logic [22:0] want, got;
    int old;
    @(negedge clk24);
    obs = gen(gp) ^ inj;
    {ce1m5, pipe_ab, video_slice, ce3, ce6x, ce6, ce12} = obs;
    clr_err = clr;
    cyc++;
    mm = (m_st == 0) ? 7'd0 : obs ^ gen(m_ph);
    old = m_ph;
    if (m_st == 0) begin
      if (obs[5] && !m_prev) begin
        m_st = 1; m_ph = 33; m_good = 0; sync_cyc = cyc;
      end
    end else begin
      m_ph = (m_ph + 1) % 64;
      if (m_st == 1) begin
        if (mm != 0) m_st = 0;
        else if (m_good == LOCK_CYCLES - 1) begin m_st = 2; m_fe = 0; end
        else m_good++;
      end else begin
        if (mm != 0) m_fe++;
        if (m_fe == ERR_LIMIT) begin m_st = 0; m_fe = 0; end
        else if (old == 63) m_fe = 0;
      end
    end
    m_prev = obs[5];
    if (clr) m_cnt = 0;
    else if (mm != 0 && m_cnt < 255) m_cnt++;
    exp_q.push_back({m_st == 2, m_st == 0 ? 6'd0 : 6'(m_ph), mm != 0, mm, 8'(m_cnt)});
    gp = (gp + 1) % 64;
    @(posedge clk24);
    #1;
    want = exp_q.pop_front();
    got = {locked, m_st == 0 ? 6'd0 : phase, err_pulse, err_mask, err_count};
    chk("sb", got, want);
  endtask

  task automatic go(input int p);
    for (int i = 0; i < 64 && gp != p; i++) step(7'd0, 1'b0);
  endtask

  task automatic wait_lock(input string tag);
    for (int i = 0; i < 400 && !locked; i++) step(7'd0, 1'b0);
    chk(tag, cyc - sync_cyc, LOCK_CYCLES);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_phase", phase, 0);
    chk("rst_pulse", err_pulse, 0);
    chk("rst_mask", err_mask, 0);
    chk("rst_count", err_count, 0);
    {ce1m5, pipe_ab, video_slice, ce3, ce6x, ce6, ce12} = 7'd0;
    clr_err = 1'b0;
    repeat (2) @(negedge clk24);
    reset_n = 1'b1;
    m_st = 0; m_ph = 0; m_prev = 1'b0; m_good = 0; m_fe = 0; m_cnt = 0; gp = 0; sync_cyc = -1000;
    exp_q.delete();
  endtask

  initial begin
    int seen;
    cyc = 0;
    do_reset();
    wait_lock("lock_lat_clean");
    repeat (10000) step(7'd0, 1'b0);
    chk("clean_count", err_count, 0);
    chk("clean_locked", locked, 1);
    go(5);
    step(7'b0001000, 1'b0);
    chk("ce3_pulse", err_pulse, 1);
    chk("ce3_mask", err_mask, 7'b0001000);
    chk("ce3_count", err_count, 1);
    chk("ce3_locked", locked, 1);
    step(7'd0, 1'b0);
    chk("ce3_pulse_end", err_pulse, 0);
    chk("ce3_mask_end", err_mask, 0);
    go(0);
    go(10); step(7'd1, 1'b0);
    go(20); step(7'd1, 1'b0);
    chk("two_glitch_locked", locked, 1);
    go(30); step(7'd1, 1'b0);
    chk("third_glitch_drop", locked, 0);
    chk("third_glitch_mask", err_mask, 7'd1);
    wait_lock("lock_lat_relock");
    go(62); step(7'd1, 1'b0); step(7'd1, 1'b0); step(7'd1, 1'b0);
    chk("wrap_locked", locked, 1);
    chk("wrap_count", err_count, 7);
    do_reset();
    for (int i = 0; i < 300 && !(m_st == 1 && m_good == 50); i++) step(7'd0, 1'b0);
    step(7'd1, 1'b0);
    chk("verify_pulse", err_pulse, 1);
    chk("verify_locked", locked, 0);
    chk("verify_count", err_count, 1);
    seen = 0;
    repeat (120) begin
      step(7'd0, 1'b0);
      if (locked) seen = 1;
    end
    chk("verify_nolock", seen, 0);
    wait_lock("lock_lat_after_verify");
    for (int f = 0; f < 200 && m_cnt < 255; f++) begin
      go(10); step(7'd1, 1'b0);
      go(20); step(7'd1, 1'b0);
    end
    chk("sat_count", err_count, 255);
    go(10); step(7'd1, 1'b0);
    chk("sat_hold", err_count, 255);
    chk("sat_pulse", err_pulse, 1);
    go(20); step(7'd1, 1'b1);
    chk("clr_wins", err_count, 0);
    chk("clr_pulse", err_pulse, 1);
    chk("clr_locked", locked, 1);
    do_reset();
    repeat (40) step(7'd0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
